// File: rtl/i2c_cmd_sequencer.sv
// Register-bus sequencer for an I2C master core: initialises the prescaler and enable,
// then expands single-register write/read commands into TXR/CR writes and SR polls.
module i2c_cmd_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter int unsigned POLL_LIMIT = 4096
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [2:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    output logic       m_we_o,
    output logic       m_stb_o,
    input  logic       m_ack_i
);

    localparam int CW = $clog2(POLL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(POLL_LIMIT);

    typedef enum logic [3:0] {
        ST_INIT_PRLO, ST_INIT_PRHI, ST_INIT_CTR, ST_IDLE,
        ST_TXR, ST_CR, ST_POLL, ST_RXR, ST_NS_CR, ST_NS_POLL
    } state_t;

    state_t          r_state, w_state_n;
    logic [1:0]      r_phase, w_phase_n;
    logic [CW-1:0]   r_poll_cnt, w_cnt_n, w_cnt_inc;
    logic            r_rd;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg, r_wdata;
    logic            r_stb, w_stb_n, r_we, w_we_n, r_ready, w_ready_n;
    logic [2:0]      r_adr, w_adr_n, w_acc_adr;
    logic [7:0]      r_dat, w_dat_n, w_acc_dat, w_txr, w_cr;
    logic            w_acc_we, w_ack, w_latch;
    logic            r_rsp_valid, w_rsp_fire;
    logic [1:0]      r_rsp_err, w_rsp_code;
    logic [7:0]      r_rsp_rdata, w_rsp_data;

    // Byte phase: 0 address, 1 register index, 2 data or repeated-start address, 3 read byte.
    always_comb begin
        case (r_phase)
            2'd0:    w_txr = {r_dev, 1'b0};
            2'd1:    w_txr = r_reg;
            default: w_txr = r_rd ? {r_dev, 1'b1} : r_wdata;
        endcase
        case (r_phase)
            2'd0:    w_cr = 8'h90;
            2'd1:    w_cr = 8'h10;
            2'd2:    w_cr = r_rd ? 8'h90 : 8'h50;
            default: w_cr = 8'h68;
        endcase
    end

    always_comb begin
        w_state_n  = r_state;
        w_phase_n  = r_phase;
        w_cnt_n    = r_poll_cnt;
        w_cnt_inc  = r_poll_cnt + CW'(1);
        w_stb_n    = r_stb;
        w_adr_n    = r_adr;
        w_dat_n    = r_dat;
        w_we_n     = r_we;
        w_ready_n  = 1'b0;
        w_latch    = 1'b0;
        w_rsp_fire = 1'b0;
        w_rsp_code = 2'b00;
        w_rsp_data = 8'h00;
        w_acc_adr  = 3'd4;
        w_acc_dat  = 8'h00;
        w_acc_we   = 1'b0;
        w_ack      = r_stb & m_ack_i;

        case (r_state)
            ST_INIT_PRLO: begin w_acc_adr = 3'd0; w_acc_dat = PRESCALE[7:0];  w_acc_we = 1'b1; end
            ST_INIT_PRHI: begin w_acc_adr = 3'd1; w_acc_dat = PRESCALE[15:8]; w_acc_we = 1'b1; end
            ST_INIT_CTR:  begin w_acc_adr = 3'd2; w_acc_dat = 8'h80;          w_acc_we = 1'b1; end
            ST_TXR:       begin w_acc_adr = 3'd3; w_acc_dat = w_txr;          w_acc_we = 1'b1; end
            ST_CR:        begin w_acc_adr = 3'd4; w_acc_dat = w_cr;           w_acc_we = 1'b1; end
            ST_NS_CR:     begin w_acc_adr = 3'd4; w_acc_dat = 8'h40;          w_acc_we = 1'b1; end
            ST_RXR:       w_acc_adr = 3'd3;
            default:      w_acc_adr = 3'd4;
        endcase

        // A state entered with strobe low spends that cycle idle, then launches its access.
        if (r_state != ST_IDLE && !r_stb) begin
            w_stb_n = 1'b1;
            w_adr_n = w_acc_adr;
            w_dat_n = w_acc_dat;
            w_we_n  = w_acc_we;
        end
        if (w_ack) w_stb_n = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready_n = !(cmd_valid && r_ready);
                if (cmd_valid && r_ready) begin
                    w_latch   = 1'b1;
                    w_phase_n = 2'd0;
                    w_state_n = ST_TXR;
                end
            end
            ST_INIT_PRLO: if (w_ack) w_state_n = ST_INIT_PRHI;
            ST_INIT_PRHI: if (w_ack) w_state_n = ST_INIT_CTR;
            ST_INIT_CTR:  if (w_ack) w_state_n = ST_IDLE;
            ST_TXR:       if (w_ack) w_state_n = ST_CR;
            ST_CR: if (w_ack) begin
                w_cnt_n   = '0;
                w_state_n = ST_POLL;
            end
            ST_POLL: if (w_ack) begin
                w_cnt_n = w_cnt_inc;
                if (m_dat_i[1]) begin
                    if (w_cnt_inc == LIMIT) begin w_rsp_fire = 1'b1; w_rsp_code = 2'b11; end
                end else if (m_dat_i[5]) begin
                    w_rsp_fire = 1'b1; w_rsp_code = 2'b10;
                end else if (r_phase == 2'd3) begin
                    w_state_n = ST_RXR;
                end else if (m_dat_i[7]) begin
                    w_state_n = ST_NS_CR;
                end else if (r_phase == 2'd2 && !r_rd) begin
                    w_rsp_fire = 1'b1;
                end else begin
                    w_phase_n = r_phase + 2'd1;
                    w_state_n = (r_phase == 2'd2) ? ST_CR : ST_TXR;
                end
            end
            ST_RXR: if (w_ack) begin
                w_rsp_fire = 1'b1;
                w_rsp_data = m_dat_i;
            end
            ST_NS_CR: if (w_ack) begin
                w_cnt_n   = '0;
                w_state_n = ST_NS_POLL;
            end
            ST_NS_POLL: if (w_ack) begin
                w_cnt_n = w_cnt_inc;
                if (!m_dat_i[6]) begin
                    w_rsp_fire = 1'b1; w_rsp_code = 2'b01;
                end else if (w_cnt_inc == LIMIT) begin
                    w_rsp_fire = 1'b1; w_rsp_code = 2'b11;
                end
            end
            default: w_state_n = ST_INIT_PRLO;
        endcase

        if (w_rsp_fire) w_state_n = ST_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_INIT_PRLO;
            r_phase     <= 2'd0;
            r_poll_cnt  <= '0;
            r_rd        <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_wdata     <= 8'd0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 3'd0;
            r_dat       <= 8'd0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 2'b00;
            r_rsp_rdata <= 8'd0;
        end else begin
            r_state     <= w_state_n;
            r_phase     <= w_phase_n;
            r_poll_cnt  <= w_cnt_n;
            r_stb       <= w_stb_n;
            r_we        <= w_we_n;
            r_adr       <= w_adr_n;
            r_dat       <= w_dat_n;
            r_ready     <= w_ready_n;
            r_rsp_valid <= w_rsp_fire;
            if (w_latch) begin
                r_rd    <= cmd_rd;
                r_dev   <= cmd_dev;
                r_reg   <= cmd_reg;
                r_wdata <= cmd_wdata;
            end
            if (w_rsp_fire) begin
                r_rsp_err   <= w_rsp_code;
                r_rsp_rdata <= w_rsp_data;
            end
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign m_stb_o   = r_stb;
    assign m_we_o    = r_we;
    assign m_adr_o   = r_adr;
    assign m_dat_o   = r_dat;

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Command-level controller for the 8-bit register interface of the I2C master core (PRER/CTR/TXR/RXR/CR/SR at addresses 0..4). After reset it initialises the prescaler and enables the core. It then turns single-register write and read commands (7-bit device, 8-bit register, 8-bit data) into the required sequence of register bus accesses and SR polls. It sits between a configuration client (sensor init ROM or CPU shim) and the I2C core, and is the only master of that register bus.

Parameters:
PRESCALE, 16'd99, prescaler value written to PRERlo/PRERhi (clk/(5*SCL)-1)
POLL_LIMIT, 4096, maximum SR reads per wait before a timeout error

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; command accepted when cmd_valid & cmd_ready
cmd_rd  in  1  1 = read, 0 = write
cmd_dev  in  7  7-bit slave address
cmd_reg  in  8  register index
cmd_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout
rsp_rdata  out  8  read data, valid with rsp_valid (0 on writes/errors)
busy  out  1  high whenever not in IDLE
m_adr_o  out  3  core register address
m_dat_o  out  8  core write data
m_dat_i  in  8  core read data
m_we_o  out  1  write enable
m_stb_o  out  1  strobe
m_ack_i  in  1  core acknowledge

Behaviour:
- Reset (synchronous, active-high): m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=1. FSM enters INIT. Reset mid-transaction aborts immediately with no STOP issued.
- Bus access: assert m_stb_o and hold adr/dat/we stable until the cycle m_ack_i=1. Read data is captured on that ack cycle. m_stb_o drops the next cycle. Exactly one idle cycle follows between accesses. There is no timeout on m_ack_i.
- INIT: write adr0=PRESCALE[7:0], adr1=PRESCALE[15:8], adr2=0x80 (EN, IEN=0), then go to IDLE.
- Command fields are latched on acceptance. cmd_ready drops the next cycle.
- POLL(n): repeatedly read SR (adr4) until TIP (bit1) = 0. After the POLL_LIMIT-th read with TIP still set, report err 11 and go to IDLE with no STOP. After TIP clears, check AL (bit5) before RxACK (bit7).
- CHK: if AL=1, go to err 10 (IDLE, no STOP). Else if RxACK=1, go to NACK_STOP.
- Write command: TXR(adr3)={dev,0}; CR(adr4)=0x90 (STA|WR); POLL; CHK; TXR=reg; CR=0x10; POLL; CHK; TXR=wdata; CR=0x50 (STO|WR); POLL; CHK; respond ok.
- Read command: TXR={dev,0}; CR=0x90; POLL; CHK; TXR=reg; CR=0x10; POLL; CHK; TXR={dev,1}; CR=0x90 (repeated start); POLL; CHK; CR=0x68 (RD|ACK=NACK|STO); POLL (AL check only); read RXR (adr3) into rsp_rdata; respond ok.
- NACK_STOP: CR=0x40; poll SR until Busy (bit6) = 0, subject to the same POLL_LIMIT (exceeding it gives err 11). Then respond err 01.
- Respond: rsp_valid=1 for one cycle with rsp_err/rsp_rdata. The FSM enters IDLE the same cycle. cmd_ready rises the following cycle, so the earliest next acceptance is 1 cycle after rsp_valid.
- rsp_err and rsp_rdata hold their values until the next rsp_valid.
- cmd_valid during busy is ignored (not queued).

Test Plan:
- Reset, model acks immediately -> bus writes in order (0,0x63),(1,0x00),(2,0x80); cmd_ready rises after the third ack.
- Write dev=0x21 reg=0x0A data=0x5C, SR returns TIP=1 twice then 0x00 -> TXR 0x42, CR 0x90, TXR 0x0A, CR 0x10, TXR 0x5C, CR 0x50; rsp_valid with err 00.
- Read dev=0x21 reg=0x03, RXR=0xA7 -> TXR 0x42/0x03/0x43, CR 0x90/0x10/0x90/0x68; rsp_rdata=0xA7, err 00.
- Address phase SR=0x80 (RxACK) -> CR=0x40 written, Busy polled to 0, rsp_err=01, no further TXR writes.
- SR=0x20 after first byte -> rsp_err=10, no STOP written. Separately, TIP stuck at 1 with POLL_LIMIT=8 -> exactly 8 SR reads, then rsp_err=11.
- Assert wb_rst_i during the second byte poll -> m_stb_o=0 next cycle, INIT sequence restarts; m_ack_i delayed 5 cycles -> stb/adr/dat held stable throughout.
